// File: rtl/rom_port_arbiter_pkg.sv
// Shared encodings for the ROM port arbiter: FSM states, requester slots,
// round-robin memory encoding and default widths.
package rom_port_arbiter_pkg;

  localparam int AW_DEF   = 18;
  localparam int DW_DEF   = 8;
  localparam int WDOG_DEF = 255;

  // Grant vectors are one-hot, indexed by these slots
  localparam int REQ_DL  = 0;
  localparam int REQ_CPU = 1;
  localparam int REQ_VID = 2;
  localparam int REQ_N   = 3;

  localparam logic RR_CPU = 1'b0;
  localparam logic RR_VID = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rom_port_rrsel.sv
// Combinational requester selector: download wins outright, CPU and video
// alternate on a tie according to who was granted last.
module rom_port_rrsel
  import rom_port_arbiter_pkg::*;
(
  input  logic             req_dl,
  input  logic             req_cpu,
  input  logic             req_vid,
  input  logic             rr_last,
  output logic [REQ_N-1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_dl) begin
      grant[REQ_DL] = 1'b1;
    end else if (req_cpu && req_vid) begin
      if (rr_last == RR_VID) grant[REQ_CPU] = 1'b1;
      else                   grant[REQ_VID] = 1'b1;
    end else if (req_cpu) begin
      grant[REQ_CPU] = 1'b1;
    end else if (req_vid) begin
      grant[REQ_VID] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one ROM/SDRAM byte port between download writes, CPU reads and video
// reads. Define ROMARB_HITCACHE_EN to add one-entry CPU/video read caches.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WDOG_CYC = WDOG_DEF
) (
  input  logic          CL,
  input  logic          RESET,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_ad,
  input  logic [DW-1:0] dl_wd,
  output logic          dl_ack,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_ad,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rd,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_ad,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rd,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_wd,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rd,
  output logic          err
);

  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYC - 1);

  arb_state_t       state, state_nxt;
  logic [REQ_N-1:0] grant, gnt_q;
  logic             rr_last;
  logic [7:0]       wdog;
  logic             take, go_mem, done_ok, abort;
  logic [AW-1:0]    sel_ad;

  rom_port_rrsel u_rrsel (
    .req_dl (dl_req),
    .req_cpu(cpu_req),
    .req_vid(vid_req),
    .rr_last(rr_last),
    .grant  (grant)
  );

`ifdef ROMARB_HITCACHE_EN
  logic [AW-1:0] cpu_tag, vid_tag;
  logic [DW-1:0] cpu_cd, vid_cd;
  logic          cpu_cv, vid_cv;
  logic          cache_hit;

  assign cache_hit = (grant[REQ_CPU] && cpu_cv && (cpu_ad == cpu_tag)) ||
                     (grant[REQ_VID] && vid_cv && (vid_ad == vid_tag));
  assign go_mem    = take & ~cache_hit;
`else
  assign go_mem    = take;
`endif

  always_comb begin
    sel_ad = dl_ad;
    if (grant[REQ_CPU])      sel_ad = cpu_ad;
    else if (grant[REQ_VID]) sel_ad = vid_ad;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done_ok   = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|grant) begin
          take = 1'b1;
`ifdef ROMARB_HITCACHE_EN
          state_nxt = cache_hit ? ST_RESP : ST_ISSUE;
`else
          state_nxt = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        // A completion on the last allowed cycle still counts as success
        if (mem_ack) begin
          done_ok   = 1'b1;
          state_nxt = ST_RESP;
        end else if (wdog == WDOG_LAST) begin
          abort     = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      dl_ack  <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      err     <= 1'b0;
      cpu_rd  <= '0;
      vid_rd  <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_ad  <= '0;
      mem_wd  <= '0;
      gnt_q   <= '0;
      rr_last <= RR_VID;
      wdog    <= '0;
`ifdef ROMARB_HITCACHE_EN
      cpu_tag <= '0;
      vid_tag <= '0;
      cpu_cd  <= '0;
      vid_cd  <= '0;
      cpu_cv  <= 1'b0;
      vid_cv  <= 1'b0;
`endif
    end else begin
      dl_ack  <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      err     <= 1'b0;

      if (take) gnt_q <= grant;

      if (go_mem) begin
        mem_req <= 1'b1;
        mem_we  <= grant[REQ_DL];
        mem_ad  <= sel_ad;
        mem_wd  <= dl_wd;
        if (grant[REQ_CPU]) rr_last <= RR_CPU;
        if (grant[REQ_VID]) rr_last <= RR_VID;
      end

`ifdef ROMARB_HITCACHE_EN
      // Hits answer straight from the cache and leave round-robin untouched
      if (take && cache_hit) begin
        cpu_ack <= grant[REQ_CPU];
        vid_ack <= grant[REQ_VID];
        if (grant[REQ_CPU]) cpu_rd <= cpu_cd;
        if (grant[REQ_VID]) vid_rd <= vid_cd;
      end
      if (take && grant[REQ_DL]) begin
        cpu_cv <= 1'b0;
        vid_cv <= 1'b0;
      end
`endif

      if (done_ok || abort) begin
        mem_req <= 1'b0;
        dl_ack  <= gnt_q[REQ_DL];
        cpu_ack <= gnt_q[REQ_CPU];
        vid_ack <= gnt_q[REQ_VID];
        err     <= abort;
        if (gnt_q[REQ_CPU]) cpu_rd <= done_ok ? mem_rd : '1;
        if (gnt_q[REQ_VID]) vid_rd <= done_ok ? mem_rd : '1;
`ifdef ROMARB_HITCACHE_EN
        if (done_ok && gnt_q[REQ_CPU]) begin
          cpu_tag <= mem_ad;
          cpu_cd  <= mem_rd;
          cpu_cv  <= 1'b1;
        end
        if (done_ok && gnt_q[REQ_VID]) begin
          vid_tag <= mem_ad;
          vid_cd  <= mem_rd;
          vid_cv  <= 1'b1;
        end
`endif
      end else if (state == ST_ISSUE) begin
        wdog <= wdog + 8'd1;
      end

      if (state == ST_RESP) wdog <= '0;
    end
  end

endmodule
